serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, LSB-first binary subtractor computing `a - b - bin` one bit per clock through a full-subtractor cell and a borrow flip-flop. It is the inverse arithmetic counterpart of the team's combinational full adder. It is used where area matters more than latency, sitting between a parallel operand source and a consumer that waits for a `done` pulse. The handshake is valid/ready on the input side and a single-cycle `done` strobe with held results on the output side.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `start_valid`  in  1: a request is presented on `a`, `b`, `bin`.
- `start_ready`  out  1: the block can accept a request; equals (state == IDLE).
- `a`  in  WIDTH: minuend, unsigned or two's complement.
- `b`  in  WIDTH: subtrahend.
- `bin`  in  1: initial borrow-in.
- `diff`  out  WIDTH: registered result, `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1: registered final borrow-out; 1 iff `a < b + bin` (unsigned).
- `done`  out  1: one-cycle pulse; `diff` and `bout` are valid from this cycle onward.
- `busy`  out  1: high while in RUN.
- `ovf`  out  1: signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - `start_ready` = 1.
  - On `start_valid & start_ready`: latch `a`→`sa`, `b`→`sb`, `bin`→`brw`; clear bit counter `cnt`; go to RUN.
- RUN, one bit per edge
  - Cell inputs are `x = sa[0]`, `y = sb[0]`, `z = brw`.
  - `d = x ^ y ^ z`; `bo = (~x & y) | (~(x ^ y) & z)`.
  - Shift `d` into the MSB of internal shift register `dsr` (right shift).
  - Shift `sa` and `sb` right by one; `brw <= bo`; `cnt <= cnt + 1`.
  - On the edge that processes bit WIDTH-1:
    - `diff <= {d, dsr[WIDTH-1:1]}`, i.e. the final shifted value.
    - `bout <= bo`.
    - Go to DONE.
- DONE: `done` = 1 for exactly one cycle; unconditionally return to IDLE.
- `diff`, `bout` and `ovf` change only on entry to DONE or on reset. They hold their values until the next result completes.
- `start_valid` is ignored whenever `start_ready` = 0. Operands may change freely after acceptance.
- `cnt` is `$clog2(WIDTH+1)` bits wide. All arithmetic is modulo 2^WIDTH; no other flags are produced.

## Timing
- Reset: a low `rst_n` at an edge forces, after that edge:
  - state = IDLE;
  - `start_ready` = 1, `busy` = 0, `done` = 0;
  - `diff` = 0, `bout` = 0, `ovf` = 0.
- Reset has priority over every other event.
- Accept edge E0 → RUN during cycles E0..E(WIDTH-1) → bits processed at edges E1..E(WIDTH).
- `done` is high in the cycle following edge E(WIDTH); `start_ready` rises after E(WIDTH+1).
- Latency from accept to `done` is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles.
- Back-to-back: `start_valid` held high is next accepted at the first edge where state = IDLE.
- Reset asserted mid-RUN aborts the operation: no `done` pulse, results cleared, partial state discarded.
- Reset asserted in the DONE cycle suppresses nothing already visible, but clears all outputs at that edge.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- Defined:
  - The `ovf` port exists.
  - On entry to DONE, `ovf <= brw_msb ^ bo`, where `brw_msb` is the borrow into bit WIDTH-1 and `bo` is the final borrow-out.
  - Equivalently, `ovf` = 1 when the signs of `a` and `b` differ and the sign of `diff` differs from the sign of `a`, taking `bin` into account.
  - `ovf` holds and resets like `diff`.
- Undefined: no `ovf` port and no associated logic. All other behaviour is identical.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x23, `bin`=0 → `done` 8 cycles after accept; `diff`=0x37, `bout`=0, `ovf`=0.
- `a`=0x10, `b`=0x20, `bin`=0 → `diff`=0xF0, `bout`=1, `ovf`=0.
- `a`=0x00, `b`=0x00, `bin`=1 → `diff`=0xFF, `bout`=1.
- With `SERIAL_SUB_OVF_EN`: `a`=0x80, `b`=0x01, `bin`=0 → `diff`=0x7F, `bout`=0, `ovf`=1.
- `start_valid` held high throughout, operands changed to 0xFF/0x01 during RUN → first result unaffected. The second operation is accepted only after DONE→IDLE and yields `diff`=0xFE. `start_ready` stays 0 for WIDTH+1 cycles.
- `rst_n` low at the third RUN edge → next cycle IDLE, all outputs 0, no `done` pulse. A subsequent 0x5A−0x23 operation yields 0x37.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial, LSB-first subtractor computing (a - b - bin) mod 2^WIDTH. It uses
// one full-subtractor cell and one borrow flip-flop, and processes one bit on
// each clock.
//
// Handshake:
//   - Input side is valid/ready. A request is accepted on an edge where
//     start_valid and start_ready are both high.
//   - Output side is a one-cycle done strobe. The registered results are held
//     until the next operation completes.
//
// Parameters
//   WIDTH        operand/result width in bits (>= 2)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   start_valid  request present on a/b/bin
//   start_ready  block idle and able to accept a request
//   a            minuend
//   b            subtrahend
//   bin          initial borrow-in
//   diff         registered result
//   bout         registered final borrow-out (a < b + bin, unsigned)
//   done         one-cycle pulse, diff/bout valid from this cycle on
//   busy         high while bits are being processed
//   ovf          signed overflow (only with SERIAL_SUB_OVF_EN)
//
// Build option
//   SERIAL_SUB_OVF_EN  when defined, adds the ovf output and its logic.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Full-subtractor cell: x - y - z
  // ---------------------------------------------------------------------------

  // Difference bit of the cell.
  function automatic logic fs_diff(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  // Borrow-out of the cell.
  function automatic logic fs_borrow(input logic x, input logic y, input logic z);
    return (~x & y) | (~(x ^ y) & z);
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------

  // Control state
  state_t           r_state;
  state_t           w_state_next;

  // Serial datapath
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;

  // Only WIDTH-1 partial bits are stored. The final bit goes straight into
  // diff together with them, so no dead flop is kept.
  logic [WIDTH-2:0] r_dsr;

  // Registered results
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  // Combinational cell and control terms
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_dsr_shift;

  // ---------------------------------------------------------------------------
  // Cell and shift-path wiring
  // ---------------------------------------------------------------------------
  assign w_accept    = start_valid && (r_state == IDLE);
  assign w_last      = (r_cnt == LAST_BIT);
  assign w_d         = fs_diff(r_sa[0], r_sb[0], r_brw);
  assign w_bo        = fs_borrow(r_sa[0], r_sb[0], r_brw);
  assign w_dsr_shift = {w_d, r_dsr};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE:    start_ready = 1'b1;
      RUN:     busy        = 1'b1;
      DONE:    done        = 1'b1;
      default: start_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand/borrow/counter shift path.
  //
  // These registers are reloaded on every accept, so they are not reset. A
  // reset returns the FSM to IDLE, which leaves their contents unused.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sa  <= a;
      r_sb  <= b;
      r_brw <= bin;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
      r_brw <= w_bo;
      r_cnt <= r_cnt + CNT_W'(1);
      r_dsr <= w_dsr_shift[WIDTH-1:1];
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers.
  //
  // Loaded only on the edge that processes the final bit (RUN -> DONE).
  // Cleared by reset, which also aborts an operation in progress.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_diff <= w_dsr_shift;
      r_bout <= w_bo;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Signed overflow is the borrow into the sign bit XOR the borrow out of it.
  // On the final edge, r_brw still holds the borrow into bit WIDTH-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_ovf <= r_brw ^ w_bo;
    end
  end

  assign ovf = r_ovf;
`endif

  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] diff;
  logic         bout;
  logic         done;
  logic         busy;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .diff        (diff),
    .bout        (bout),
    .done        (done),
    .busy        (busy)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle.
  // Applies one request, then checks latency, results and hold behaviour.
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input logic [W-1:0] ed, input logic eb, input logic eo);
    int lat;
    check({tag, " ready"}, 32'(start_ready), 32'd1);
    a = ia;
    b = ib;
    bin = ibin;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    a = ~ia;            // operands may change after acceptance
    b = ~ib;
    bin = ~ibin;
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < W + 4) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(W));
    check({tag, " diff"}, 32'(diff), 32'(ed));
    check({tag, " bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
`endif
    tick();
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " ready after"}, 32'(start_ready), 32'd1);
    check({tag, " diff held"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    int low;
    int lat;
    int seen_done;

    //            a      b      bin   diff   bout  ovf
    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[8] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};

    rst_n = 1'b0;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("reset ready", 32'(start_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
             vecs[i].diff, vecs[i].bout, vecs[i].ovf);
    end

    // Back-to-back: start_valid is held high and operands change during RUN.
    a = 8'h5A;
    b = 8'h23;
    bin = 1'b0;
    start_valid = 1'b1;
    tick();
    a = 8'hFF;
    b = 8'h01;
    low = 0;
    seen_done = 0;
    for (int k = 0; k < 3 * W; k++) begin
      if (start_ready) break;
      low++;
      if (done) begin
        seen_done++;
        check("b2b first diff", 32'(diff), 32'h37);
        check("b2b first bout", 32'(bout), 32'd0);
      end
      tick();
    end
    check("b2b first done seen", 32'(seen_done), 32'd1);
    check("b2b ready low cycles", 32'(low), 32'(W + 1));
    tick();
    check("b2b second accepted", 32'(busy), 32'd1);
    start_valid = 1'b0;
    lat = 0;
    while (!done && lat < W + 4) begin
      tick();
      lat++;
    end
    check("b2b second latency", 32'(lat), 32'(W));
    check("b2b second diff", 32'(diff), 32'hFE);
    check("b2b second bout", 32'(bout), 32'd0);
    tick();

    // Reset at the third RUN edge aborts the operation.
    a = 8'h10;
    b = 8'h20;
    start_valid = 1'b1;
    tick();                 // accept edge E0
    start_valid = 1'b0;
    tick();                 // E1
    tick();                 // E2
    rst_n = 1'b0;
    tick();                 // E3 with reset low
    check("abort ready", 32'(start_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort diff", 32'(diff), 32'd0);
    check("abort bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < W + 3; k++) begin
      tick();
      if (done) seen_done++;
    end
    check("abort no done", 32'(seen_done), 32'd0);
    run_op("after abort", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);

    // Reset in the DONE cycle clears results at that edge.
    a = 8'hA5;
    b = 8'h5A;
    bin = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    lat = 0;
    while (!done && lat < W + 4) begin
      tick();
      lat++;
    end
    check("done-rst diff before", 32'(diff), 32'h4B);
    rst_n = 1'b0;
    tick();
    check("done-rst diff", 32'(diff), 32'd0);
    check("done-rst done", 32'(done), 32'd0);
    check("done-rst ready", 32'(start_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
